// File: rtl/camera_pkg.sv
// Shared definitions for the camera edge-tracking blocks: FSM encoding,
// column width, the "no edge" code and a saturating increment.
package camera_pkg;

    localparam int COL_W = 8;
    localparam logic [COL_W-1:0] NO_EDGE = 8'hFF;

    typedef enum logic [2:0] {
        WAIT_FRAME = 3'd0,
        WAIT_LINE  = 3'd1,
        IN_LINE    = 3'd2,
        FLUSH      = 3'd3,
        REPORT     = 3'd4
    } state_t;

    function automatic logic [COL_W-1:0] sat_inc(input logic [COL_W-1:0] v);
        return (v == '1) ? v : v + COL_W'(1);
    endfunction

endpackage

// File: rtl/edge_run_detect.sv
// Column qualifier and edge-run detector: counts pixel strobes, maps them to
// effective columns and records first/last run start and run count of a line.
module edge_run_detect
    import camera_pkg::*;
#(
    parameter int LINE_WIDTH = 176,
    parameter int PIPE_DELAY = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             strobe_i,
    input  logic             edge_i,
    output logic [COL_W-1:0] first_col_o,
    output logic [COL_W-1:0] last_col_o,
    output logic [COL_W-1:0] edge_count_o
);

    localparam logic [COL_W-1:0] DELAY_C = COL_W'(PIPE_DELAY);

    logic [COL_W-1:0] raw_col_q, raw_col_d;
    logic [COL_W-1:0] first_q, first_d;
    logic [COL_W-1:0] last_q, last_d;
    logic [COL_W-1:0] count_q, count_d;
    logic             prev_q, prev_d;
    logic [COL_W-1:0] eff_col;
    logic             qualified;
    logic             run_start;

    // The edge flag for a pixel lags its strobe by PIPE_DELAY, so the window of
    // trusted flags spans raw strobes PIPE_DELAY .. LINE_WIDTH-1.
    always_comb begin
        eff_col   = raw_col_q - DELAY_C;
        qualified = strobe_i
                    && (int'(raw_col_q) >= PIPE_DELAY)
                    && (int'(raw_col_q) < LINE_WIDTH);
        run_start = qualified && edge_i && !prev_q;
    end

    always_comb begin
        raw_col_d = raw_col_q;
        first_d   = first_q;
        last_d    = last_q;
        count_d   = count_q;
        prev_d    = prev_q;
        if (clear_i) begin
            raw_col_d = '0;
            first_d   = NO_EDGE;
            last_d    = NO_EDGE;
            count_d   = '0;
            prev_d    = 1'b0;
        end else begin
            if (strobe_i) begin
                raw_col_d = sat_inc(raw_col_q);
            end
            if (qualified) begin
                prev_d = edge_i;
            end
            if (run_start) begin
                if (count_q == '0) begin
                    first_d = eff_col;
                end
                last_d  = eff_col;
                count_d = sat_inc(count_q);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            raw_col_q <= '0;
            first_q   <= NO_EDGE;
            last_q    <= NO_EDGE;
            count_q   <= '0;
            prev_q    <= 1'b0;
        end else begin
            raw_col_q <= raw_col_d;
            first_q   <= first_d;
            last_q    <= last_d;
            count_q   <= count_d;
            prev_q    <= prev_d;
        end
    end

    // Next-state view so the final strobe of a line is included when reporting.
    assign first_col_o  = first_d;
    assign last_col_o   = last_d;
    assign edge_count_o = count_d;

endmodule

// File: rtl/edge_line_tracker.sv
// Per-line edge tracker: frame/line FSM around edge_run_detect, publishing
// first/last run column, run count and line index once per camera line.
module edge_line_tracker
    import camera_pkg::*;
#(
    parameter int LINE_WIDTH = 176,
    parameter int PIPE_DELAY = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PIXEL_VALID,
    input  logic       HREF,
    input  logic       VSYNC,
    input  logic       EDGE,
    output logic       LINE_VALID,
    output logic [7:0] FIRST_COL,
    output logic [7:0] LAST_COL,
    output logic [7:0] EDGE_COUNT,
    output logic [7:0] LINE_NUM
);

    state_t           state_q, state_d;
    logic [COL_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [COL_W-1:0] line_idx_q, line_idx_d;
    logic             line_valid_q, line_valid_d;
    logic [COL_W-1:0] first_q, first_d;
    logic [COL_W-1:0] last_q, last_d;
    logic [COL_W-1:0] count_q, count_d;
    logic [COL_W-1:0] line_num_q, line_num_d;

    logic             run_active;
    logic             flush_done;
    logic             report_go;
    logic             abort;
    logic [COL_W-1:0] det_first;
    logic [COL_W-1:0] det_last;
    logic [COL_W-1:0] det_count;

    assign run_active = (state_q == IN_LINE) || (state_q == FLUSH);
    assign flush_done = (PIPE_DELAY == 0)
                        || (PIXEL_VALID && (int'(flush_cnt_q) == PIPE_DELAY - 1));
    assign abort      = VSYNC && (state_q != WAIT_FRAME);
    // A VSYNC on the closing strobe kills the report before it is published.
    assign report_go  = (state_q == FLUSH) && flush_done && !VSYNC;

    edge_run_detect #(
        .LINE_WIDTH (LINE_WIDTH),
        .PIPE_DELAY (PIPE_DELAY)
    ) u_detect (
        .clk_i        (CLK),
        .rst_i        (RESET),
        .clear_i      (!run_active),
        .strobe_i     (PIXEL_VALID && run_active),
        .edge_i       (EDGE),
        .first_col_o  (det_first),
        .last_col_o   (det_last),
        .edge_count_o (det_count)
    );

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        line_idx_d   = line_idx_q;
        line_valid_d = 1'b0;
        first_d      = first_q;
        last_d       = last_q;
        count_d      = count_q;
        line_num_d   = line_num_q;

        case (state_q)
            WAIT_FRAME: begin
                line_idx_d = '0;
                if (!VSYNC) begin
                    state_d = WAIT_LINE;
                end
            end
            WAIT_LINE: begin
                flush_cnt_d = '0;
                if (HREF) begin
                    state_d = IN_LINE;
                end
            end
            IN_LINE: begin
                if (!HREF) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_done) begin
                    state_d = REPORT;
                end else if (PIXEL_VALID) begin
                    flush_cnt_d = flush_cnt_q + COL_W'(1);
                end
            end
            REPORT: begin
                line_idx_d = sat_inc(line_idx_q);
                state_d    = WAIT_LINE;
            end
            default: begin
                state_d = WAIT_FRAME;
            end
        endcase

        // Outputs are loaded on entry to REPORT so the pulse and data align.
        if (report_go) begin
            line_valid_d = 1'b1;
            first_d      = det_first;
            last_d       = det_last;
            count_d      = det_count;
            line_num_d   = line_idx_q;
        end

        if (abort) begin
            state_d = WAIT_FRAME;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= WAIT_FRAME;
            flush_cnt_q  <= '0;
            line_idx_q   <= '0;
            line_valid_q <= 1'b0;
            first_q      <= NO_EDGE;
            last_q       <= NO_EDGE;
            count_q      <= '0;
            line_num_q   <= '0;
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            line_idx_q   <= line_idx_d;
            line_valid_q <= line_valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            count_q      <= count_d;
            line_num_q   <= line_num_d;
        end
    end

    assign LINE_VALID = line_valid_q;
    assign FIRST_COL  = first_q;
    assign LAST_COL   = last_q;
    assign EDGE_COUNT = count_q;
    assign LINE_NUM   = line_num_q;

endmodule

// File: tb/tb_edge_line_tracker.sv
// Directed bench for edge_line_tracker: scripted lines and frame events with
// hand-computed line results checked by immediate assertions.
module tb_edge_line_tracker;

    logic       CLK;
    logic       RESET;
    logic       PIXEL_VALID;
    logic       HREF;
    logic       VSYNC;
    logic       EDGE;
    logic       LINE_VALID;
    logic [7:0] FIRST_COL;
    logic [7:0] LAST_COL;
    logic [7:0] EDGE_COUNT;
    logic [7:0] LINE_NUM;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;
    int pc_before;

    edge_line_tracker #(
        .LINE_WIDTH (176),
        .PIPE_DELAY (6)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .PIXEL_VALID (PIXEL_VALID),
        .HREF        (HREF),
        .VSYNC       (VSYNC),
        .EDGE        (EDGE),
        .LINE_VALID  (LINE_VALID),
        .FIRST_COL   (FIRST_COL),
        .LAST_COL    (LAST_COL),
        .EDGE_COUNT  (EDGE_COUNT),
        .LINE_NUM    (LINE_NUM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance one cycle; inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge CLK);
        if (LINE_VALID === 1'b1) pulse_cnt++;
    endtask

    function automatic logic edge_at(input int mode, input int raw);
        case (mode)
            1: return ((raw >= 16) && (raw <= 18)) || (raw == 40);
            2: return raw < 6;
            3: return (raw >= 6) && (((raw - 6) % 2) == 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_line(input int mode, input int n_in, input int n_flush, input bit vs_last);
        HREF = 1'b1; PIXEL_VALID = 1'b0; EDGE = 1'b0;
        tick();
        for (int raw = 0; raw < n_in; raw++) begin
            PIXEL_VALID = 1'b1;
            EDGE = edge_at(mode, raw);
            tick();
            if ((raw % 4) == 3) begin
                PIXEL_VALID = 1'b0;
                EDGE = 1'b1;
                tick();
            end
        end
        PIXEL_VALID = 1'b0; EDGE = 1'b0; HREF = 1'b0;
        tick();
        for (int k = 0; k < n_flush; k++) begin
            PIXEL_VALID = 1'b1;
            EDGE = edge_at(mode, n_in + k);
            if (vs_last && (k == n_flush - 1)) VSYNC = 1'b1;
            tick();
        end
        PIXEL_VALID = 1'b0; EDGE = 1'b0;
    endtask

    task automatic expect_report(input string name, input int f, input int l, input int c, input int n);
        chk({name, "_latency"}, 32'(LINE_VALID), 32'd1);
        tick();
        chk({name, "_pulse_end"}, 32'(LINE_VALID), 32'd0);
        chk({name, "_first"}, 32'(FIRST_COL), 32'(f));
        chk({name, "_last"}, 32'(LAST_COL), 32'(l));
        chk({name, "_count"}, 32'(EDGE_COUNT), 32'(c));
        chk({name, "_num"}, 32'(LINE_NUM), 32'(n));
    endtask

    task automatic new_frame();
        VSYNC = 1'b1;
        tick(); tick();
        VSYNC = 1'b0;
        tick(); tick();
    endtask

    initial begin
        RESET = 1'b1; PIXEL_VALID = 1'b0; HREF = 1'b0; VSYNC = 1'b0; EDGE = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(LINE_VALID), 32'd0);
        chk("rst_first", 32'(FIRST_COL), 32'd255);
        chk("rst_last", 32'(LAST_COL), 32'd255);
        chk("rst_count", 32'(EDGE_COUNT), 32'd0);
        chk("rst_num", 32'(LINE_NUM), 32'd0);
        RESET = 1'b0;
        tick();

        // Frame 1: edges, empty line, pre-delay-only edges.
        new_frame();
        do_line(1, 50, 6, 1'b0);
        expect_report("lineA", 10, 34, 2, 0);
        tick(); tick();
        do_line(0, 50, 6, 1'b0);
        expect_report("empty", 255, 255, 0, 1);
        tick();
        do_line(2, 20, 6, 1'b0);
        expect_report("predelay", 255, 255, 0, 2);
        for (int i = 0; i < 5; i++) tick();
        chk("hold_first", 32'(FIRST_COL), 32'd255);
        chk("hold_num", 32'(LINE_NUM), 32'd2);

        // VSYNC mid-line aborts without a report.
        pc_before = pulse_cnt;
        HREF = 1'b1; tick();
        for (int raw = 0; raw < 24; raw++) begin
            PIXEL_VALID = 1'b1; EDGE = edge_at(1, raw); tick();
        end
        PIXEL_VALID = 1'b0; EDGE = 1'b0; VSYNC = 1'b1;
        tick(); tick(); tick();
        HREF = 1'b0; tick();
        chk("abort_no_pulse", 32'(pulse_cnt), 32'(pc_before));
        chk("abort_first_held", 32'(FIRST_COL), 32'd255);
        chk("abort_num_held", 32'(LINE_NUM), 32'd2);
        VSYNC = 1'b0; tick(); tick();
        do_line(1, 50, 6, 1'b0);
        expect_report("frame2", 10, 34, 2, 0);
        tick();

        // VSYNC on the closing flush strobe beats the report.
        pc_before = pulse_cnt;
        do_line(3, 200, 6, 1'b1);
        tick(); tick();
        chk("vs_report_no_pulse", 32'(pulse_cnt), 32'(pc_before));
        chk("vs_report_first_held", 32'(FIRST_COL), 32'd10);
        chk("vs_report_count_held", 32'(EDGE_COUNT), 32'd2);
        VSYNC = 1'b0; tick(); tick();

        // Alternating edges across 200 qualified pixels.
        do_line(3, 200, 6, 1'b0);
        expect_report("alt", 0, 168, 85, 0);
        tick();

        // Reset asserted while in FLUSH.
        pc_before = pulse_cnt;
        do_line(1, 50, 3, 1'b0);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_first", 32'(FIRST_COL), 32'd255);
        chk("async_rst_last", 32'(LAST_COL), 32'd255);
        chk("async_rst_count", 32'(EDGE_COUNT), 32'd0);
        chk("async_rst_valid", 32'(LINE_VALID), 32'd0);
        tick(); tick();
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) begin
            PIXEL_VALID = (i % 2 == 0); tick();
        end
        PIXEL_VALID = 1'b0;
        chk("flush_rst_no_pulse", 32'(pulse_cnt), 32'(pc_before));
        chk("flush_rst_num", 32'(LINE_NUM), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
